// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//
// Debounce and auto-repeat one mechanical push-button. The raw pin is
// synchronised and normalised to "1 = pressed". It then has to hold its
// new level for DEBOUNCE_TICKS consecutive sampling ticks before the
// debounced level changes. A small FSM turns debounced edges into
// one-cycle press/release strobes. While the button is held, it also
// produces auto-repeat press strobes.
//
// Parameters
//   DEBOUNCE_TICKS : consecutive ticks a new level must persist (>= 1)
//   REPEAT_DELAY   : ticks from the debounced press to the first repeat
//                    (0 disables auto-repeat)
//   REPEAT_PERIOD  : ticks between successive repeats (>= 1)
//   ACTIVE_LOW     : 1 when a pressed button reads 0 on key_i
//
// Ports
//   clock     : system clock
//   reset     : asynchronous, active-high reset
//   tick_i    : one-cycle sampling strobe (period >= 2 cycles)
//   key_i     : raw asynchronous button pin
//   key_o     : debounced level, 1 = pressed
//   press_o   : one-cycle strobe on a debounced press and on each repeat
//   repeat_o  : high together with press_o when the strobe is a repeat
//   release_o : one-cycle strobe on a debounced release
// ---------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic key_i,
  output logic key_o,
  output logic press_o,
  output logic repeat_o,
  output logic release_o
);

  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W    = $clog2(REP_MAX + 1);

  // Terminal values are compared before incrementing. The completing tick
  // is therefore the one that would bring the count up to the target.
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
  localparam bit              REPEAT_EN   = (REPEAT_DELAY > 0);

  // Pin level of an unpressed button.
  localparam logic IDLE_LEVEL = ACTIVE_LOW;

  // ------------------------------------------------------------------
  // Parameter sanity checks at elaboration time
  // ------------------------------------------------------------------
  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_TICKS must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("key_debouncer: REPEAT_PERIOD must be >= 1");
  end
  if (REPEAT_DELAY < 0) begin : g_bad_delay
    $error("key_debouncer: REPEAT_DELAY must be >= 0");
  end

  // ------------------------------------------------------------------
  // Input synchroniser and polarity normalisation
  // ------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_key_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // ------------------------------------------------------------------
  // Debounce counter
  // ------------------------------------------------------------------
  logic            r_key;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_mismatch;
  logic            w_db_done;
  logic            w_press_evt;
  logic            w_release_evt;

  assign w_mismatch    = w_key_s ^ r_key;
  assign w_db_done     = tick_i & w_mismatch & (r_db_cnt == DB_LAST);
  assign w_press_evt   = w_db_done & ~r_key;
  assign w_release_evt = w_db_done &  r_key;

  // The count is cleared whenever the synchronised level agrees with the
  // debounced level, even without a tick. A glitch that lands between
  // ticks therefore restarts the whole qualification window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key    <= 1'b0;
      r_db_cnt <= '0;
    end else if (!w_mismatch) begin
      r_db_cnt <= '0;
    end else if (tick_i) begin
      if (w_db_done) begin
        r_key    <= ~r_key;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Press / repeat / release FSM with registered strobes
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  state_t          r_state;
  logic [RC_W-1:0] r_rep_cnt;
  logic            r_press;
  logic            r_repeat;
  logic            r_release;

  // The release event is tested first in every held state. If a release
  // completes on the same tick as a repeat count, only release_o pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RELEASED;
      r_rep_cnt <= '0;
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;

      case (r_state)
        ST_RELEASED: begin
          if (w_press_evt) begin
            r_press   <= 1'b1;
            r_rep_cnt <= '0;
            r_state   <= ST_HELD;
          end
        end

        ST_HELD: begin
          if (w_release_evt) begin
            r_release <= 1'b1;
            r_state   <= ST_RELEASED;
          end else if (tick_i && r_key && REPEAT_EN) begin
            if (r_rep_cnt == DELAY_LAST) begin
              r_press   <= 1'b1;
              r_repeat  <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= ST_REPEATING;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end

        ST_REPEATING: begin
          if (w_release_evt) begin
            r_release <= 1'b1;
            r_state   <= ST_RELEASED;
          end else if (tick_i) begin
            if (r_rep_cnt == PERIOD_LAST) begin
              r_press   <= 1'b1;
              r_repeat  <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_RELEASED;
        end
      endcase
    end
  end

  assign key_o     = r_key;
  assign press_o   = r_press;
  assign repeat_o  = r_repeat;
  assign release_o = r_release;

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounces and auto-repeats one mechanical push-button for the Lissajous controller front panel. The block sits directly downstream of the tick generator and uses its one-cycle `tick_o` strobe as the time base for sampling. It outputs a clean key level plus one-cycle press/release strobes, and the frequency-ratio and phase control logic consumes those strobes. One instance is used per button.

## Interface
- `DEBOUNCE_TICKS`, default 20: number of consecutive ticks on which the new level must be seen before `key_o` changes. Must be ≥1; elaboration-time assert.
- `REPEAT_DELAY`, default 500: ticks from the debounced press to the first auto-repeat. A value of 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 100: ticks between successive auto-repeats. Must be ≥1; elaboration-time assert.
- `ACTIVE_LOW`, default 1: 1 means a pressed button reads 0 on `key_i`.
- `clock` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high; clock `clock`.
- `tick_i` in 1: sampling strobe from the tick generator, one cycle wide, period ≥2 cycles.
- `key_i` in 1: raw asynchronous button pin.
- `key_o` out 1: debounced level, 1 = pressed.
- `press_o` out 1: one-cycle strobe on a debounced press and on each auto-repeat.
- `repeat_o` out 1: high together with `press_o` only when that strobe is an auto-repeat.
- `release_o` out 1: one-cycle strobe on a debounced release.

## Operation
- **Input conditioning:** `key_i` passes through a 2-flop synchronizer. It is then inverted if `ACTIVE_LOW` = 1, giving `key_s` (1 = pressed).
- **Reset values:**
  - Synchronizer flops reset to the idle (not pressed) level.
  - All outputs reset to 0.
  - The debounce counter, the repeat counter and the FSM reset to 0 / RELEASED.
- **Debounce counter:**
  - Width is $clog2(DEBOUNCE_TICKS+1).
  - Any cycle with `key_s` == `key_o` clears the counter. This holds whether or not a tick is present, so a glitch between ticks restarts the count.
  - A cycle with `tick_i` = 1 and `key_s` != `key_o` increments the counter.
  - When an increment would reach `DEBOUNCE_TICKS`:
    - `key_o` toggles on that edge and the counter clears.
    - A 0→1 transition is a debounced press event; a 1→0 transition is a debounced release event.
- **Repeat FSM states:** RELEASED, HELD, REPEATING. The repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - RELEASED, on a press event: `press_o` = 1 next cycle, `repeat_o` = 0; clear the repeat counter; go to HELD.
  - HELD, on each tick with `key_o` = 1: increment the repeat counter. When it reaches `REPEAT_DELAY`: `press_o` = `repeat_o` = 1 for one cycle, counter clears, go to REPEATING.
  - HELD with `REPEAT_DELAY` = 0: stay in HELD and never repeat.
  - REPEATING, on each tick: increment the repeat counter. When it reaches `REPEAT_PERIOD`: `press_o` = `repeat_o` = 1 for one cycle, counter clears, stay in REPEATING.
  - Any state other than RELEASED, on a release event: `release_o` = 1 for one cycle; go to RELEASED.
- **Priority:** a release event on the same tick that would complete a repeat count wins. In that case `release_o` pulses and `press_o` does not.
- **Exclusivity:** `press_o` and `release_o` are never high in the same cycle.
- **Reset mid-operation:** all state is lost. A button held through reset is re-debounced from zero and produces a fresh non-repeat press after `DEBOUNCE_TICKS` ticks.

## Timing
- All outputs are registered.
- `key_o`, `press_o` and `release_o` change on the clock edge that consumes the completing tick. They are therefore valid in the cycle after that tick.
- Worst-case latency from a `key_i` edge to `key_o`: 2 cycles (synchronizer) + `DEBOUNCE_TICKS` tick periods + 1 cycle.
- Auto-repeat strobes:
  - The first auto-repeat `press_o` comes exactly `REPEAT_DELAY` ticks after the tick that produced the initial press.
  - Later strobes follow every `REPEAT_PERIOD` ticks.
- Pulse width: `press_o`, `repeat_o` and `release_o` are exactly 1 cycle, independent of the tick period.
- Without ticks, no counter advances. Mismatch clearing still happens every cycle.

## Test plan
Common setup: `DEBOUNCE_TICKS`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `ACTIVE_LOW`=1, tick every 8 cycles.

1. **Reset:** assert `reset` with `key_i`=1 idle → all outputs 0. No strobes for 100 cycles after deassert.
2. **Clean press:** drive `key_i`=0 and hold it → `key_o` rises and `press_o` pulses 1 cycle (`repeat_o`=0), both in the cycle after the 4th tick following synchronization.
3. **Bounce:** press for 3 ticks, release for 1 cycle between ticks, then press again → `key_o` stays 0 until 4 further consecutive ticks; exactly one `press_o`.
4. **Auto-repeat:** hold for 20 ticks after the initial press tick T0 → `press_o` with `repeat_o`=1 at ticks T0+10, +13, +16 and +19 (4 repeats, each 1 cycle).
5. **Release:** release after scenario 4, with the release completing on tick T0+22 where a repeat is also due → `release_o` 1 cycle, no `press_o`; FSM in RELEASED; no further strobes.
6. **Reset mid-repeat:** pulse `reset` while holding in REPEATING → outputs 0 immediately. After deassert, a non-repeat `press_o` arrives after 4 ticks.
